systolic_feeder: RTL and testbench
==================================

// Module: systolic_feeder
// PURPOSE
//  Operand sequencer directly upstream of the 3x3 weight-stationary-free MAC systolic array.
//  Buffers a 3x3 matrix A and a 3x3 matrix B written by the host.
//  On start, streams A rows into a1..a3 and B columns into b1..b3 with diagonal skew.
//  Then waits for the array to drain and pulses done, so c1..c9 hold C = A x B.
// PARAMETERS
//  data_size     32  operand width; equals the array's data_size
//  DRAIN_CYCLES  4   idle-zero cycles after the last fed beat before done; min 1
// PORTS
//  clk      in   1          single clock, rising edge
//  rst      in   1          asynchronous, active-low reset (0 = reset)
//  wr_en    in   1          host write strobe
//  wr_sel   in   1          0 = matrix A, 1 = matrix B
//  wr_addr  in   4          row-major element index 0..8 (row*3+col)
//  wr_data  in   data_size  element value
//  start    in   1          single-cycle request to run one multiply
//  busy     out  1          high from the cycle after start acceptance until done inclusive
//  done     out  1          one-cycle pulse: products complete at array outputs
//  a1..a3   out  data_size  array row operands (registered)
//  b1..b3   out  data_size  array column operands (registered)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; busy=0, done=0, a1..a3=b1..b3=0; both buffers cleared to 0.
//  - FSM states and transitions:
//    - IDLE -> FEED on start.
//    - FEED -> DRAIN after 5 beats; t counts 0..4.
//    - DRAIN -> DONE after DRAIN_CYCLES cycles.
//    - DONE lasts 1 cycle -> IDLE.
//  - Start sampled at edge E0 (in IDLE): FEED beat t drives outputs during cycle E0+1+t.
//    - DRAIN occupies the next DRAIN_CYCLES cycles.
//    - done is high in cycle E0+6+DRAIN_CYCLES (cycle 10 with the default).
//  - Skew, beat t, i/j = 1..3:
//    - a_i = A[i-1][t-(i-1)] if 0 <= t-(i-1) <= 2, else 0.
//    - b_j = B[t-(j-1)][j-1] if 0 <= t-(j-1) <= 2, else 0.
//  - In IDLE, DRAIN and DONE all a/b outputs are 0, so array accumulators hold their values.
//  - Writes: accepted only when not busy.
//    - wr_addr > 8 is ignored.
//    - A write is visible to a start sampled on the same edge.
//  - start while busy is ignored. start in the DONE cycle is ignored; the host reissues it in IDLE.
//  - Clearing the array accumulators between runs is the system's job (array reset). The feeder does not clear them.
//  - Reset mid-run aborts immediately: outputs go to 0 and no done pulse is produced.
//  - Arithmetic: none. Values pass through bit-exact with no sign interpretation.
// STRUCTURE
//  - npu_defs.vh (shared include): DATA_SIZE, ARR_N=3, FEED_BEATS=2*ARR_N-1, and the FSM state encodings.
//  - Sub-module feeder_buf: 9-entry x data_size register file, one write port and 3 parallel combinational read ports.
//    - Instantiated twice (A, B).
//    - The top holds the FSM, beat counter, skew muxing and output registers.
// TESTING
//  - Reset: assert rst=0 mid-FEED -> next cycle all a/b=0, busy=0; no done pulse follows.
//  - A=[1..9] row-major, B=identity, start at E0. Required outputs per cycle:
//    - E0+1: a=(1,0,0), b=(1,0,0).
//    - E0+2: a=(2,4,0), b=(0,0,0).
//    - E0+3: a=(3,5,7), b=(0,1,0).
//    - E0+5: a=(0,0,9), b=(0,0,1).
//    - done in E0+10.
//    - With the array attached: c1..c9=1..9.
//  - A=all 2, B=all 3 -> every c=18. busy high E0+1..E0+10.
//  - start while busy, plus writes while busy -> ignored: a second run reproduces identical results and no extra done.
//  - wr_addr=9..15 writes -> no buffer change. A write on the start edge -> the new value appears in the stream.
//  - DRAIN_CYCLES=1 build -> done in E0+7. Back-to-back start the cycle after done -> accepted.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared constants and FSM encoding for the 3x3 systolic-array operand feeder.
package systolic_feeder_pkg;

    localparam int unsigned DataSizeDef = 32;
    localparam int unsigned ArrN        = 3;
    localparam int unsigned FeedBeats   = 2 * ArrN - 1;
    localparam int unsigned NumElems    = ArrN * ArrN;
    localparam int unsigned AddrW       = 4;
    localparam int unsigned BeatW       = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFeed  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/systolic_feeder_buf.sv
// 9-entry operand buffer: one write port, ArrN combinational read ports.
module systolic_feeder_buf
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DataSize = DataSizeDef
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [AddrW-1:0]         waddr_i,
    input  logic [DataSize-1:0]      wdata_i,
    input  logic [ArrN*AddrW-1:0]    raddr_i,
    output logic [ArrN*DataSize-1:0] rdata_o
);

    logic [DataSize-1:0] mem_q [NumElems];
    logic                wr_hit;
    logic [AddrW-1:0]    raddr;

    assign wr_hit = we_i && (waddr_i < AddrW'(NumElems));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NumElems; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < NumElems; e++) begin
                if (wr_hit && (waddr_i == AddrW'(e))) begin
                    mem_q[e] <= wdata_i;
                end
            end
        end
    end

    // Write-through so a write on the start edge reaches the first fed beat.
    always_comb begin
        rdata_o = '0;
        raddr   = '0;
        for (int r = 0; r < ArrN; r++) begin
            raddr = raddr_i[r*AddrW +: AddrW];
            for (int e = 0; e < NumElems; e++) begin
                if (raddr == AddrW'(e)) begin
                    rdata_o[r*DataSize +: DataSize] =
                        (wr_hit && (waddr_i == raddr)) ? wdata_i : mem_q[e];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers matrices A and B and streams them into a 3x3 systolic array with diagonal skew.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned DataSize    = DataSizeDef,
    parameter int unsigned DrainCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic                wr_sel_i,
    input  logic [AddrW-1:0]    wr_addr_i,
    input  logic [DataSize-1:0] wr_data_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [DataSize-1:0] a1_o,
    output logic [DataSize-1:0] a2_o,
    output logic [DataSize-1:0] a3_o,
    output logic [DataSize-1:0] b1_o,
    output logic [DataSize-1:0] b2_o,
    output logic [DataSize-1:0] b3_o
);

    localparam int unsigned CntW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

    state_e                    state_q, state_d;
    logic [BeatW-1:0]          beat_q, beat_d;
    logic [CntW-1:0]           drain_q, drain_d;
    logic [ArrN*DataSize-1:0]  a_q, a_d, b_q, b_d;

    logic                      idle;
    logic                      wr_ok;
    logic                      feed_vld;
    logic [BeatW-1:0]          feed_t;
    logic [BeatW-1:0]          off;
    logic [ArrN-1:0]           lane_vld;
    logic [ArrN*AddrW-1:0]     raddr_a, raddr_b;
    logic [ArrN*DataSize-1:0]  rdata_a, rdata_b;

    assign idle  = (state_q == StIdle);
    assign wr_ok = wr_en_i && idle;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFeed;
                    beat_d  = '0;
                end
            end
            StFeed: begin
                if (beat_q == BeatW'(FeedBeats - 1)) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == CntW'(DrainCycles - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output registers are loaded one beat ahead: beat 0 on the start edge.
    assign feed_vld = (idle && start_i) ||
                      ((state_q == StFeed) && (beat_q != BeatW'(FeedBeats - 1)));
    assign feed_t   = idle ? '0 : beat_q + 1'b1;

    always_comb begin
        raddr_a  = '0;
        raddr_b  = '0;
        lane_vld = '0;
        off      = '0;
        for (int k = 0; k < ArrN; k++) begin
            off = feed_t - BeatW'(k);
            if (feed_vld && (feed_t >= BeatW'(k)) && (off < BeatW'(ArrN))) begin
                lane_vld[k] = 1'b1;
                raddr_a[k*AddrW +: AddrW] = AddrW'(k * ArrN) + AddrW'(off);
                raddr_b[k*AddrW +: AddrW] = AddrW'(off * ArrN) + AddrW'(k);
            end
        end
    end

    always_comb begin
        a_d = '0;
        b_d = '0;
        for (int k = 0; k < ArrN; k++) begin
            if (lane_vld[k]) begin
                a_d[k*DataSize +: DataSize] = rdata_a[k*DataSize +: DataSize];
                b_d[k*DataSize +: DataSize] = rdata_b[k*DataSize +: DataSize];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            beat_q  <= '0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    systolic_feeder_buf #(
        .DataSize(DataSize)
    ) u_buf_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_ok && !wr_sel_i),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .raddr_i (raddr_a),
        .rdata_o (rdata_a)
    );

    systolic_feeder_buf #(
        .DataSize(DataSize)
    ) u_buf_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_ok && wr_sel_i),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .raddr_i (raddr_b),
        .rdata_o (rdata_b)
    );

    assign busy_o = !idle;
    assign done_o = (state_q == StDone);
    assign a1_o   = a_q[0*DataSize +: DataSize];
    assign a2_o   = a_q[1*DataSize +: DataSize];
    assign a3_o   = a_q[2*DataSize +: DataSize];
    assign b1_o   = b_q[0*DataSize +: DataSize];
    assign b2_o   = b_q[1*DataSize +: DataSize];
    assign b3_o   = b_q[2*DataSize +: DataSize];

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench: default build plus a DrainCycles=1 build driven in lockstep.
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, wr_sel, start;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    logic        busy0, done0, busy1, done1;
    logic [31:0] a1_0, a2_0, a3_0, b1_0, b2_0, b3_0;
    logic [31:0] a1_1, a2_1, a3_1, b1_1, b2_1, b3_1;

    logic [31:0] ma [9];
    logic [31:0] mb [9];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_feeder u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start),
        .busy_o(busy0), .done_o(done0),
        .a1_o(a1_0), .a2_o(a2_0), .a3_o(a3_0), .b1_o(b1_0), .b2_o(b2_0), .b3_o(b3_0)
    );

    systolic_feeder #(.DrainCycles(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start),
        .busy_o(busy1), .done_o(done1),
        .a1_o(a1_1), .a2_o(a2_1), .a3_o(a3_1), .b1_o(b1_1), .b2_o(b2_1), .b3_o(b3_1)
    );

    // Reference: row i of A enters lane i delayed by i beats; column j of B likewise.
    function automatic logic [95:0] exp_a(int t);
        logic [95:0] r = '0;
        for (int i = 0; i < 3; i++) begin
            if (t >= 0 && t <= 4 && t - i >= 0 && t - i <= 2) r[i*32 +: 32] = ma[i*3 + (t-i)];
        end
        return r;
    endfunction

    function automatic logic [95:0] exp_b(int t);
        logic [95:0] r = '0;
        for (int j = 0; j < 3; j++) begin
            if (t >= 0 && t <= 4 && t - j >= 0 && t - j <= 2) r[j*32 +: 32] = mb[(t-j)*3 + j];
        end
        return r;
    endfunction

    task automatic model_write(input logic sel, input logic [3:0] addr, input logic [31:0] d);
        if (addr < 4'd9) begin
            if (sel) mb[addr] = d;
            else     ma[addr] = d;
        end
    endtask

    task automatic do_write(input logic sel, input logic [3:0] addr, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model_write(sel, addr, d);
    endtask

    // Entered #1 after a rising edge with both DUTs idle; leaves them idle the same way.
    task automatic run_mult(input string name, input bit noise, input bit ws_en,
                            input logic ws_sel, input logic [3:0] ws_addr, input logic [31:0] ws_data);
        logic [95:0] ea, eb, g;
        start = 1'b1; wr_en = ws_en; wr_sel = ws_sel; wr_addr = ws_addr; wr_data = ws_data;
        if (ws_en) model_write(ws_sel, ws_addr, ws_data);
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            ea = exp_a(k - 1);
            eb = exp_b(k - 1);
            g = {a3_0, a2_0, a1_0}; checks++;
            if (g !== ea) begin errors++; $display("FAIL %s a d4 cyc%0d got %h exp %h", name, k, g, ea); end
            g = {b3_0, b2_0, b1_0}; checks++;
            if (g !== eb) begin errors++; $display("FAIL %s b d4 cyc%0d got %h exp %h", name, k, g, eb); end
            g = {a3_1, a2_1, a1_1}; checks++;
            if (g !== ea) begin errors++; $display("FAIL %s a d1 cyc%0d got %h exp %h", name, k, g, ea); end
            g = {b3_1, b2_1, b1_1}; checks++;
            if (g !== eb) begin errors++; $display("FAIL %s b d1 cyc%0d got %h exp %h", name, k, g, eb); end
            checks++;
            if (busy0 !== (k <= 10)) begin errors++; $display("FAIL %s busy d4 cyc%0d got %b", name, k, busy0); end
            checks++;
            if (done0 !== (k == 10)) begin errors++; $display("FAIL %s done d4 cyc%0d got %b", name, k, done0); end
            checks++;
            if (busy1 !== (k <= 7)) begin errors++; $display("FAIL %s busy d1 cyc%0d got %b", name, k, busy1); end
            checks++;
            if (done1 !== (k == 7)) begin errors++; $display("FAIL %s done d1 cyc%0d got %b", name, k, done1); end
            // Both builds are busy through cycle 7, so these must all be dropped.
            if (noise && k <= 7) begin
                start = 1'($urandom); wr_en = 1'($urandom); wr_sel = 1'($urandom);
                wr_addr = 4'($urandom); wr_data = $urandom;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (k < 11) begin @(posedge clk); #1; end
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        for (int e = 0; e < 9; e++) begin ma[e] = '0; mb[e] = '0; end
        #2;
        checks++;
        if ({a1_0, a2_0, a3_0, b1_0, b2_0, b3_0, busy0, done0} !== '0) begin
            errors++; $display("FAIL reset d4 outputs not zero busy=%b done=%b", busy0, done0);
        end
        checks++;
        if ({a1_1, a2_1, a3_1, b1_1, b2_1, b3_1, busy1, done1} !== '0) begin
            errors++; $display("FAIL reset d1 outputs not zero busy=%b done=%b", busy1, done1);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        for (int e = 0; e < 9; e++) do_write(1'b0, 4'(e), 32'(e + 1));
        for (int e = 0; e < 9; e++) do_write(1'b1, 4'(e), (e % 4 == 0) ? 32'd1 : 32'd0);
        run_mult("identity", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_const();
        for (int e = 0; e < 9; e++) begin
            do_write(1'b0, 4'(e), 32'd2);
            do_write(1'b1, 4'(e), 32'd3);
        end
        run_mult("const", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_busy_ignore();
        for (int e = 0; e < 9; e++) begin
            do_write(1'b0, 4'(e), $urandom);
            do_write(1'b1, 4'(e), $urandom);
        end
        run_mult("busy_noise", 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        run_mult("rerun", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_bad_addr();
        for (int a = 9; a < 16; a++) begin
            do_write(1'b0, 4'(a), $urandom);
            do_write(1'b1, 4'(a), $urandom);
        end
        run_mult("bad_addr", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_start_write();
        run_mult("start_wr_a00", 1'b0, 1'b1, 1'b0, 4'd0, $urandom);
        run_mult("start_wr_b22", 1'b0, 1'b1, 1'b1, 4'd8, $urandom);
        run_mult("start_wr_a12", 1'b0, 1'b1, 1'b0, 4'd5, $urandom);
    endtask

    task automatic test_back_to_back();
        run_mult("b2b_first", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        run_mult("b2b_second", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a1_0, a2_0, a3_0, b1_0, b2_0, b3_0, busy0} !== '0) begin
            errors++; $display("FAIL midrun_reset d4 outputs not cleared busy=%b a1=%h", busy0, a1_0);
        end
        checks++;
        if ({a1_1, a2_1, a3_1, b1_1, b2_1, b3_1, busy1} !== '0) begin
            errors++; $display("FAIL midrun_reset d1 outputs not cleared busy=%b a1=%h", busy1, a1_1);
        end
        for (int e = 0; e < 9; e++) begin ma[e] = '0; mb[e] = '0; end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0) begin
                errors++; $display("FAIL midrun_reset stray done cyc%0d got %b%b exp 00", k, done0, done1);
            end
        end
        run_mult("after_reset_cleared", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_const();
        test_busy_ignore();
        test_bad_addr();
        test_start_write();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
